rush3d_framebuffer_writer: RTL and testbench

//  Downstream of the rush3d controller. Drains rasterised pixels from the pixel FIFO into the back buffer.

---
 rtl/rush3d_framebuffer_writer_if.sv | 14 +
 rtl/rush3d_framebuffer_writer.sv | 135 +++++++++++++
 tb/tb_rush3d_framebuffer_writer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rush3d_framebuffer_writer_if.sv
// Avalon-MM write-only bus between the framebuffer writer and memory.
//   avm_address     byte address of the pixel being written
//   avm_writedata   RGB565 pixel
//   avm_write       write request
//   avm_waitrequest slave stall; address/data held while write && waitrequest
interface rush3d_framebuffer_writer_if;
  logic [31:0] avm_address;
  logic [15:0] avm_writedata;
  logic        avm_write;
  logic        avm_waitrequest;

  modport master (output avm_address, avm_writedata, avm_write, input avm_waitrequest);
  modport slave  (input avm_address, avm_writedata, avm_write, output avm_waitrequest);
endinterface

// File: rtl/rush3d_framebuffer_writer.sv
// rush3d_framebuffer_writer
// Drains rasterised pixels from a show-ahead pixel FIFO into the back buffer,
// and clears the back buffer to a background colour on a controller fill request.
// One RGB565 pixel per Avalon-MM write.
// Ports:
//   clock, reset_n            clock, synchronous active-low reset
//   fill_background_flag      fill request (level, held until state 3 seen)
//   current_buffer_flag       front buffer select; back = ~flag (0->FB1, 1->FB0)
//   background_colour         fill colour
//   pixel_fifo_q/empty/rdreq  show-ahead FIFO {x[35:26], y[25:16], colour[15:0]}
//   avm                       Avalon-MM write master (rush3d_framebuffer_writer_if)
//   framebuffer_write_state   0 WAIT, 1 WRITE, 2 PURGE, 3 BACKGROUND
// Optional: define RUSH3D_FB_STATS_EN to add pixel_count / drop_count outputs.
module rush3d_framebuffer_writer #(
  parameter int          FB_WIDTH  = 640,
  parameter int          FB_HEIGHT = 480,
  parameter logic [31:0] FB0_BASE  = 32'h0000_0000,
  parameter logic [31:0] FB1_BASE  = 32'h0009_6000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         fill_background_flag,
  input  logic                         current_buffer_flag,
  input  logic [15:0]                  background_colour,
  input  logic [35:0]                  pixel_fifo_q,
  input  logic                         pixel_fifo_empty,
  output logic                         pixel_fifo_rdreq,
  rush3d_framebuffer_writer_if.master  avm,
  output logic [3:0]                   framebuffer_write_state
`ifdef RUSH3D_FB_STATS_EN
  ,
  output logic [31:0]                  pixel_count,
  output logic [15:0]                  drop_count
`endif
);

  typedef enum logic [1:0] {
    S_WAIT       = 2'd0,
    S_WRITE      = 2'd1,
    S_PURGE      = 2'd2,
    S_BACKGROUND = 2'd3
  } state_t;

  localparam logic [19:0] FILL_LAST = 20'(FB_WIDTH * FB_HEIGHT - 1);

  state_t      state;
  logic [19:0] fill_cnt;

  logic [9:0]  px, py;
  logic [31:0] back_base, pix_offset;
  logic        clip, accept, pop;

  assign px         = pixel_fifo_q[35:26];
  assign py         = pixel_fifo_q[25:16];
  assign back_base  = current_buffer_flag ? FB0_BASE : FB1_BASE;
  assign clip       = ({22'd0, px} >= 32'(FB_WIDTH)) || ({22'd0, py} >= 32'(FB_HEIGHT));
  assign pix_offset = ({22'd0, py} * 32'(FB_WIDTH) + {22'd0, px}) << 1;
  assign accept     = avm.avm_write && !avm.avm_waitrequest;

  // The pop is decoded from registered state so the show-ahead word is
  // latched on the same edge it is popped: pop at N, avm_write at N+1.
  // Gated by reset_n so no pixel is lost while reset is held.
  assign pop              = reset_n && (state == S_WAIT) && !fill_background_flag && !pixel_fifo_empty;
  assign pixel_fifo_rdreq = pop;

  assign framebuffer_write_state = {2'b00, state};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= S_WAIT;
      fill_cnt          <= '0;
      avm.avm_write     <= 1'b0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
`ifdef RUSH3D_FB_STATS_EN
      pixel_count       <= '0;
      drop_count        <= '0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          if (fill_background_flag) begin
            avm.avm_writedata <= background_colour;
            avm.avm_address   <= back_base;
            avm.avm_write     <= 1'b1;
            fill_cnt          <= '0;
            state             <= S_PURGE;
`ifdef RUSH3D_FB_STATS_EN
            pixel_count       <= '0;
            drop_count        <= '0;
`endif
          end else if (!pixel_fifo_empty) begin
            if (clip) begin
`ifdef RUSH3D_FB_STATS_EN
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
            end else begin
              avm.avm_address   <= back_base + pix_offset;
              avm.avm_writedata <= pixel_fifo_q[15:0];
              avm.avm_write     <= 1'b1;
              state             <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (accept) begin
            avm.avm_write <= 1'b0;
            state         <= S_WAIT;
`ifdef RUSH3D_FB_STATS_EN
            pixel_count   <= pixel_count + 32'd1;
`endif
          end
        end
        S_PURGE: begin
          // The address walks alongside the counter, so it always equals
          // base + fill_cnt*2 without a multiplier.
          if (accept) begin
            if (fill_cnt == FILL_LAST) begin
              avm.avm_write <= 1'b0;
              state         <= S_BACKGROUND;
            end else begin
              fill_cnt        <= fill_cnt + 20'd1;
              avm.avm_address <= avm.avm_address + 32'd2;
            end
          end
        end
        S_BACKGROUND: begin
          if (!fill_background_flag) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rush3d_framebuffer_writer.sv
module tb_rush3d_framebuffer_writer;
  // Small frame keeps full fills short: 20x12 = 240 pixels, buffer 1 at 0x1E0.
  localparam int          W  = 20;
  localparam int          H  = 12;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_01E0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fill = 1'b0;
  logic        cbuf = 1'b0;
  logic [15:0] bg = 16'h0;
  logic [35:0] q;
  logic        empty, rdreq;
  logic [3:0]  st;
`ifdef RUSH3D_FB_STATS_EN
  logic [31:0] pc;
  logic [15:0] dc;
`endif

  rush3d_framebuffer_writer_if avm_bus();

  rush3d_framebuffer_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .FB0_BASE(B0), .FB1_BASE(B1)) dut (
    .clock(clock), .reset_n(reset_n),
    .fill_background_flag(fill), .current_buffer_flag(cbuf), .background_colour(bg),
    .pixel_fifo_q(q), .pixel_fifo_empty(empty), .pixel_fifo_rdreq(rdreq),
    .avm(avm_bus.master), .framebuffer_write_state(st)
`ifdef RUSH3D_FB_STATS_EN
    , .pixel_count(pc), .drop_count(dc)
`endif
  );

  always #5 clock = ~clock;

  // Show-ahead FIFO model
  logic [35:0] fmem [0:63];
  logic [5:0]  wp = 6'd0, rp = 6'd0;
  int          rd_cnt = 0, pop_err = 0;
  assign empty = (wp == rp);
  assign q     = fmem[rp];

  always @(posedge clock) begin
    if (rdreq) begin
      if (empty) pop_err <= pop_err + 1;
      rp     <= rp + 6'd1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Bus monitor: record accepted writes, check stall stability
  logic [31:0] acc_addr [$];
  logic [15:0] acc_data [$];
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] paddr = '0;
  logic [15:0] pdata = '0;

  always @(posedge clock) begin
    if (avm_bus.avm_write && !avm_bus.avm_waitrequest) begin
      acc_addr.push_back(avm_bus.avm_address);
      acc_data.push_back(avm_bus.avm_writedata);
    end
    if (prev_stall && (!avm_bus.avm_write || avm_bus.avm_address != paddr || avm_bus.avm_writedata != pdata))
      stab_err <= stab_err + 1;
    prev_stall <= reset_n && avm_bus.avm_write && avm_bus.avm_waitrequest;
    paddr      <= avm_bus.avm_address;
    pdata      <= avm_bus.avm_writedata;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [15:0] c);
    fmem[wp] = {x, y, c};
    wp = wp + 6'd1;
  endtask

  typedef struct {
    logic [9:0]  x, y;
    logic [15:0] c;
    logic        cb;
    logic        ok;
    logic [31:0] addr;
  } vec_t;

  vec_t vt [8];

  initial begin
    int a0, a1, r0, bad, cyc;

    vt[0] = '{x:10'd3,    y:10'd2,    c:16'hF800, cb:1'b0, ok:1'b1, addr:32'h236};
    vt[1] = '{x:10'd19,   y:10'd11,   c:16'h07E0, cb:1'b1, ok:1'b1, addr:32'h1DE};
    vt[2] = '{x:10'd0,    y:10'd0,    c:16'h1234, cb:1'b0, ok:1'b1, addr:32'h1E0};
    vt[3] = '{x:10'd20,   y:10'd0,    c:16'h1111, cb:1'b0, ok:1'b0, addr:32'h0};
    vt[4] = '{x:10'd0,    y:10'd12,   c:16'h2222, cb:1'b1, ok:1'b0, addr:32'h0};
    vt[5] = '{x:10'd1023, y:10'd1023, c:16'h3333, cb:1'b0, ok:1'b0, addr:32'h0};
    vt[6] = '{x:10'd5,    y:10'd7,    c:16'hABCD, cb:1'b1, ok:1'b1, addr:32'h122};
    vt[7] = '{x:10'd19,   y:10'd0,    c:16'hFFFF, cb:1'b0, ok:1'b1, addr:32'h206};

    avm_bus.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", st, 4'd0);
    chk("reset_write", avm_bus.avm_write, 1'b0);
    chk("reset_addr",  avm_bus.avm_address, 32'h0);
    chk("reset_data",  avm_bus.avm_writedata, 16'h0);
    chk("reset_rdreq", rdreq, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);

    // Table-driven single pixels, including clip boundaries
    for (int i = 0; i < 8; i++) begin
      cbuf = vt[i].cb;
      r0 = rd_cnt;
      a0 = acc_addr.size();
      push(vt[i].x, vt[i].y, vt[i].c);
      #1;
      chk("pop_rdreq", rdreq, 1'b1);
      @(negedge clock);
      if (vt[i].ok) begin
        chk("px_write", avm_bus.avm_write, 1'b1);
        chk("px_addr",  avm_bus.avm_address, vt[i].addr);
        chk("px_data",  avm_bus.avm_writedata, vt[i].c);
        chk("px_state", st, 4'd1);
      end else begin
        chk("clip_write", avm_bus.avm_write, 1'b0);
        chk("clip_state", st, 4'd0);
      end
      @(negedge clock);
      chk("px_done_write", avm_bus.avm_write, 1'b0);
      chk("px_done_state", st, 4'd0);
      chk("px_pops", rd_cnt - r0, 1);
      chk("px_accepts", acc_addr.size() - a0, {31'd0, vt[i].ok});
    end
`ifdef RUSH3D_FB_STATS_EN
    chk("stat_pixels", pc, 32'd5);
    chk("stat_drops", dc, 16'd3);
`endif

    // Stalled pixel: 5 stall cycles, second pixel queued, buffer toggled mid-write
    avm_bus.avm_waitrequest = 1'b1;
    cbuf = 1'b0;
    a0 = acc_addr.size();
    push(10'd3, 10'd2, 16'hF800);
    #1;
    chk("stall_pop", rdreq, 1'b1);
    @(negedge clock);
    chk("stall_write", avm_bus.avm_write, 1'b1);
    chk("stall_addr", avm_bus.avm_address, 32'h236);
    cbuf = 1'b1;
    push(10'd1, 10'd1, 16'h0F0F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_hold_write", avm_bus.avm_write, 1'b1);
      chk("stall_hold_addr",  avm_bus.avm_address, 32'h236);
      chk("stall_hold_data",  avm_bus.avm_writedata, 16'hF800);
      chk("stall_no_pop", rdreq, 1'b0);
    end
    avm_bus.avm_waitrequest = 1'b0;
    @(negedge clock);
    chk("stall_done_state", st, 4'd0);
    chk("stall_single_accept", acc_addr.size() - a0, 1);
    chk("next_pop", rdreq, 1'b1);
    @(negedge clock);
    chk("next_addr", avm_bus.avm_address, 32'h02A);
    chk("next_data", avm_bus.avm_writedata, 16'h0F0F);
    @(negedge clock);
    chk("next_done", avm_bus.avm_write, 1'b0);

    // Fill with a pixel waiting: fill wins, pixel written after BACKGROUND->WAIT
    fill = 1'b1;
    bg = 16'h001F;
    cbuf = 1'b1;
    push(10'd2, 10'd1, 16'hBEEF);
    a0 = acc_addr.size();
    r0 = rd_cnt;
    #1;
    chk("fill_priority_no_pop", rdreq, 1'b0);
    @(negedge clock);
    chk("fill_state", st, 4'd2);
    chk("fill_first_addr", avm_bus.avm_address, 32'h0);
    cyc = 0;
    while (cyc < 2000 && st == 4'd2) begin
      avm_bus.avm_waitrequest = (cyc % 7 == 3);
      if (cyc == 50) cbuf = 1'b0;
      cyc++;
      @(negedge clock);
    end
    avm_bus.avm_waitrequest = 1'b0;
    chk("fill_done_state", st, 4'd3);
    chk("fill_done_write", avm_bus.avm_write, 1'b0);
    chk("fill_count", acc_addr.size() - a0, W * H);
    bad = 0;
    for (int i = 0; i < W * H && a0 + i < acc_addr.size(); i++)
      if (acc_addr[a0 + i] != 32'(i * 2) || acc_data[a0 + i] != 16'h001F) bad++;
    chk("fill_contents_bad", bad, 0);
    repeat (2) @(negedge clock);
    chk("bg_hold_state", st, 4'd3);
    chk("fill_no_pops", rd_cnt - r0, 0);
    fill = 1'b0;
    @(negedge clock);
    chk("bg_exit_state", st, 4'd0);
    chk("after_fill_pop", rdreq, 1'b1);
    @(negedge clock);
    chk("after_fill_write", avm_bus.avm_write, 1'b1);
    chk("after_fill_addr", avm_bus.avm_address, 32'h20C);
    chk("after_fill_data", avm_bus.avm_writedata, 16'hBEEF);
    @(negedge clock);
    chk("after_fill_done", avm_bus.avm_write, 1'b0);
`ifdef RUSH3D_FB_STATS_EN
    chk("stat_pixels_after_fill", pc, 32'd1);
    chk("stat_drops_after_fill", dc, 16'd0);
`endif

    // Flag drop mid-fill does not abort; reset mid-fill abandons; refill restarts at base
    fill = 1'b1;
    bg = 16'hAAAA;
    cbuf = 1'b0;
    @(negedge clock);
    chk("fill2_state", st, 4'd2);
    chk("fill2_base", avm_bus.avm_address, 32'h1E0);
    repeat (3) @(negedge clock);
    fill = 1'b0;
    repeat (100) @(negedge clock);
    chk("fill2_no_abort", st, 4'd2);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midreset_write", avm_bus.avm_write, 1'b0);
    chk("midreset_state", st, 4'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("postreset_state", st, 4'd0);
    fill = 1'b1;
    cbuf = 1'b1;
    a1 = acc_addr.size();
    @(negedge clock);
    chk("restart_state", st, 4'd2);
    chk("restart_addr", avm_bus.avm_address, 32'h0);
    chk("restart_data", avm_bus.avm_writedata, 16'hAAAA);
    cyc = 0;
    while (cyc < 2000 && st == 4'd2) begin
      cyc++;
      @(negedge clock);
    end
    chk("restart_done_state", st, 4'd3);
    chk("restart_count", acc_addr.size() - a1, W * H);
    if (acc_addr.size() >= a1 + W * H)
      chk("restart_last_addr", acc_addr[a1 + W * H - 1], 32'h1DE);
    else
      chk("restart_last_addr", acc_addr.size(), a1 + W * H);
    fill = 1'b0;
    @(negedge clock);
    chk("restart_exit_state", st, 4'd0);

    chk("avalon_stability_errors", stab_err, 0);
    chk("pop_when_empty_errors", pop_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
